// File: rtl/sram_stream_pkg.sv
// Shared definitions for the SRAM read streamer: FSM state encoding and
// elastic-buffer sizing.
package sram_stream_pkg;
  localparam int RD_FIFO_DEPTH = 2;
  localparam int RD_CNT_W      = $clog2(RD_FIFO_DEPTH + 1);

  typedef logic [1:0] state_t;
  localparam state_t IDLE  = 2'd0;
  localparam state_t RUN   = 2'd1;
  localparam state_t DRAIN = 2'd2;
endpackage

// File: rtl/sram_rd_fifo2.sv
// Two-entry elastic buffer holding {last, data} beats returned by the SRAM.
module sram_rd_fifo2
  import sram_stream_pkg::*;
#(
  parameter int W = 129
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                push,
  input  logic [W-1:0]        din,
  input  logic                pop,
  output logic [W-1:0]        dout,
  output logic [RD_CNT_W-1:0] cnt
);
  logic [RD_FIFO_DEPTH-1:0][W-1:0] mem;
  logic                            rd_ptr, wr_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem    <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      cnt    <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      cnt <= cnt + RD_CNT_W'(push) - RD_CNT_W'(pop);
    end
  end

  assign dout = mem[rd_ptr];
endmodule

// File: rtl/sram_rd_streamer.sv
// Streams (base, len[, stride]) SRAM reads into a valid/ready stream; DMA writes
// own the port when present. Optional SRAM_RD_STRIDE_EN adds a per-command stride.
module sram_rd_streamer
  import sram_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 128,
  parameter int DEPTH      = 2048,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_base,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
`ifdef SRAM_RD_STRIDE_EN
  input  logic [ADDR_WIDTH-1:0] cmd_stride,
`endif
  output logic                  busy,
  output logic                  done,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  sram_en,
  output logic                  sram_we,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_wdata,
  input  logic [DATA_WIDTH-1:0] sram_rdata
);
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   cur_addr, addr_nxt, step;
  logic [ADDR_WIDTH:0]     addr_sum;
  logic [LEN_WIDTH-1:0]    remaining;
  logic                    inflight, last_q, pop, rd_issue;
  logic [RD_CNT_W-1:0]     fifo_cnt;
  logic [DATA_WIDTH:0]     fifo_dout;

`ifdef SRAM_RD_STRIDE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      step <= '0;
    else if (cmd_valid && cmd_ready)
      step <= ({1'b0, cmd_stride} >= DEPTH_W) ? ADDR_WIDTH'({1'b0, cmd_stride} - DEPTH_W)
                                               : cmd_stride;
  end
`else
  assign step = ADDR_WIDTH'(1);
`endif

  // Address advance wraps modulo DEPTH, which also covers non-power-of-2 depths.
  assign addr_sum = {1'b0, cur_addr} + {1'b0, step};
  assign addr_nxt = (addr_sum >= DEPTH_W) ? ADDR_WIDTH'(addr_sum - DEPTH_W)
                                          : addr_sum[ADDR_WIDTH-1:0];

  // Issue only when the beat is guaranteed a FIFO slot, counting the read in flight.
  always_comb begin
    pop      = m_valid & m_ready;
    rd_issue = !wr_valid && (state == RUN) && (remaining != '0) &&
               (({1'b0, fifo_cnt} + {2'b0, inflight} - {2'b0, pop}) < 3'd2);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cur_addr  <= '0;
      remaining <= '0;
      inflight  <= 1'b0;
      last_q    <= 1'b0;
      done      <= 1'b0;
    end else begin
      done     <= 1'b0;
      inflight <= rd_issue;
      if (rd_issue) begin
        last_q    <= (remaining == LEN_WIDTH'(1));
        cur_addr  <= addr_nxt;
        remaining <= remaining - LEN_WIDTH'(1);
      end
      case (state)
        IDLE: if (cmd_valid) begin
          cur_addr  <= cmd_base;
          remaining <= cmd_len;
          if (cmd_len == '0) done  <= 1'b1;
          else               state <= RUN;
        end
        RUN: if (rd_issue && remaining == LEN_WIDTH'(1)) state <= DRAIN;
        // Finish on the edge that pops the final beat so done lands right after it.
        DRAIN: if (!inflight && fifo_cnt == RD_CNT_W'(pop)) begin
          state <= IDLE;
          done  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  sram_rd_fifo2 #(.W(DATA_WIDTH + 1)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (inflight),
    .din   ({last_q, sram_rdata}),
    .pop   (pop),
    .dout  (fifo_dout),
    .cnt   (fifo_cnt)
  );

  assign {m_last, m_data} = fifo_dout;
  assign m_valid    = (fifo_cnt != '0);
  assign cmd_ready  = (state == IDLE);
  assign busy       = (state != IDLE);
  assign wr_ready   = 1'b1;
  assign sram_en    = wr_valid | rd_issue;
  assign sram_we    = wr_valid;
  assign sram_addr  = wr_valid ? wr_addr : (rd_issue ? cur_addr : '0);
  assign sram_wdata = wr_valid ? wr_data : '0;
endmodule

// File: tb/tb_sram_rd_streamer.sv
// Randomized/directed bench for sram_rd_streamer with an SRAM model and an
// address/data reference computed from (base + i*stride) mod DEPTH.
module tb_sram_rd_streamer;
  localparam int DW = 32, DEPTH = 2048, AW = 11, LW = 12;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          cmd_valid, cmd_ready, busy, done, wr_valid, wr_ready;
  logic          m_valid, m_ready, m_last, sram_en, sram_we;
  logic [AW-1:0] cmd_base, wr_addr, sram_addr;
  logic [LW-1:0] cmd_len;
  logic [DW-1:0] wr_data, m_data, sram_wdata, sram_rdata;
`ifdef SRAM_RD_STRIDE_EN
  logic [AW-1:0] cmd_stride;
`endif

  sram_rd_streamer #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_base(cmd_base), .cmd_len(cmd_len),
`ifdef SRAM_RD_STRIDE_EN
    .cmd_stride(cmd_stride),
`endif
    .busy(busy), .done(done), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_last(m_last), .sram_en(sram_en), .sram_we(sram_we),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  logic [DW-1:0] mem    [DEPTH];
  logic [DW-1:0] shadow [DEPTH];
  int  cyc = 0;
  int  errs = 0, checks = 0;
  int  acc_cyc, wr_cyc, done_cyc, n_done, max_out, rdy_mode, stall_left;
  bit  done_ok;
  logic [AW-1:0] rd_addr_q[$];
  int            rd_cyc_q[$];
  logic [DW:0]   beat_q[$];
  int            beat_cyc_q[$];

  // SRAM: 1-cycle read latency
  always @(posedge clk) begin
    if (sram_en) begin
      if (sram_we) mem[sram_addr] = sram_wdata;
      else         sram_rdata <= mem[sram_addr];
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (cmd_valid && cmd_ready) acc_cyc = cyc;
      if (sram_en && sram_we) wr_cyc = cyc;
      if (sram_en && !sram_we) begin
        rd_addr_q.push_back(sram_addr);
        rd_cyc_q.push_back(cyc);
      end
      if (m_valid && m_ready) begin
        beat_q.push_back({m_last, m_data});
        beat_cyc_q.push_back(cyc);
      end
      if (done) begin
        done_cyc = cyc;
        n_done++;
        done_ok = !busy && cmd_ready;
      end
      if (rd_addr_q.size() - beat_q.size() > max_out) max_out = rd_addr_q.size() - beat_q.size();
    end
  end

  initial begin
    m_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0: m_ready = 1'b1;
        1: m_ready = ($urandom % 4) != 0;
        default: if (beat_q.size() == 1 && stall_left > 0) begin
          m_ready = 1'b0;
          stall_left--;
        end else m_ready = 1'b1;
      endcase
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    rd_addr_q.delete(); rd_cyc_q.delete(); beat_q.delete(); beat_cyc_q.delete();
    n_done = 0; max_out = 0; done_ok = 0; acc_cyc = -100; wr_cyc = -100; done_cyc = -100;
  endtask

  task automatic do_write(input int a, input int d);
    @(posedge clk); #1;
    wr_valid = 1'b1; wr_addr = AW'(a); wr_data = DW'(d);
    @(posedge clk); #1;
    wr_valid = 1'b0;
    shadow[a] = DW'(d);
  endtask

  // wr_at > 0 drives one write wr_at cycles after the command handshake cycle
  task automatic run_cmd(input int base, input int len, input int stride, input int mode,
                         input int wr_at, input int wa, input int wd, input bit tput);
    int k, st, a, slip;
`ifdef SRAM_RD_STRIDE_EN
    st = stride;
`else
    st = 1;
`endif
    clear_mon();
    rdy_mode = mode;
    stall_left = (mode == 2) ? 5 : 0;
    @(posedge clk); #1;
    cmd_base = AW'(base); cmd_len = LW'(len); cmd_valid = 1'b1;
`ifdef SRAM_RD_STRIDE_EN
    cmd_stride = AW'(stride);
`endif
    if (wr_at > 0) shadow[wa] = DW'(wd);
    k = 0;
    while (n_done == 0 && k < 300) begin
      @(posedge clk); #1;
      k++;
      cmd_valid = 1'b0;
      wr_valid = (k == wr_at);
      wr_addr = AW'(wa); wr_data = DW'(wd);
    end
    wr_valid = 1'b0;
    chk("done_count", n_done, 1);
    chk("occupancy_le2", max_out <= 2, 1);
    chk("done_idle", done_ok, 1);
    if (len == 0) begin
      chk("len0_reads", rd_addr_q.size(), 0);
      chk("len0_done_lat", done_cyc, acc_cyc + 1);
    end else begin
      chk("n_reads", rd_addr_q.size(), len);
      chk("n_beats", beat_q.size(), len);
      for (int i = 0; i < len && i < rd_addr_q.size() && i < beat_q.size(); i++) begin
        a = (base + i * st) % DEPTH;
        chk("rd_addr", rd_addr_q[i], a);
        chk("beat_data", beat_q[i][DW-1:0], shadow[a]);
        chk("beat_last", beat_q[i][DW], i == len - 1);
        if (tput) begin
          slip = (wr_at > 0 && i >= wr_at - 1) ? 1 : 0;
          chk("rd_cycle", rd_cyc_q[i], acc_cyc + 1 + i + slip);
        end
      end
      if (beat_cyc_q.size() > 0) chk("done_lat", done_cyc, beat_cyc_q[$] + 1);
      if (wr_at > 0) chk("wr_slot", wr_cyc, acc_cyc + wr_at);
      if (tput && wr_at == 0 && beat_cyc_q.size() == len)
        chk("beat_streak", beat_cyc_q[len-1] - beat_cyc_q[0], len - 1);
    end
  endtask

  initial begin
    cmd_valid = 0; cmd_base = 0; cmd_len = 0; wr_valid = 0; wr_addr = 0; wr_data = 0;
    rdy_mode = 0; stall_left = 0;
`ifdef SRAM_RD_STRIDE_EN
    cmd_stride = 0;
`endif
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = DW'(i);
      shadow[i] = DW'(i);
    end
    clear_mon();
    #2;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_wr_ready", wr_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_sram_en", sram_en, 0);
    chk("rst_done", done, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    run_cmd(10, 4, 1, 0, 0, 0, 0, 1);
    run_cmd(10, 4, 1, 2, 0, 0, 0, 0);
    run_cmd(10, 4, 1, 0, 3, 12, 'hAA, 1);
    run_cmd(DEPTH - 2, 4, 1, 0, 0, 0, 0, 1);
`ifdef SRAM_RD_STRIDE_EN
    run_cmd(0, 3, 3, 0, 0, 0, 0, 1);
    run_cmd(7, 3, 0, 0, 0, 0, 0, 1);
`endif
    run_cmd(5, 0, 1, 0, 0, 0, 0, 0);

    // reset in the middle of a stream
    clear_mon();
    rdy_mode = 0;
    @(posedge clk); #1;
    cmd_base = 100; cmd_len = 8; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("pre_rst_busy", busy, 1);
    chk("pre_rst_m_valid", m_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_m_valid", m_valid, 0);
    chk("mid_rst_sram_en", sram_en, 0);
    chk("mid_rst_cmd_ready", cmd_ready, 1);
    chk("mid_rst_m_last", m_last, 0);
    chk("mid_rst_m_data", m_data, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    run_cmd(300, 6, 1, 0, 0, 0, 0, 1);

    for (int t = 0; t < 8; t++) begin
      int b, l, s;
      do_write($urandom_range(0, DEPTH - 1), $urandom);
      b = $urandom_range(0, DEPTH - 1);
      l = $urandom_range(1, 12);
      s = $urandom_range(0, DEPTH - 1);
      run_cmd(b, l, s, 1, 0, 0, 0, 0);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/sram_rd_streamer.md
# sram_rd_streamer

Read-stream controller sitting between the NPU buffer consumers and a single-port synchronous SRAM (1-cycle read latency). It accepts a (base, length) read command and walks the SRAM, converting its fixed-latency read data into a valid/ready stream with a 2-entry elastic buffer so that backpressure never loses data. It also owns the SRAM's single port: it muxes in a DMA-side write channel that always takes priority over streaming reads.

## Interface
Parameters:
- DATA_WIDTH, 128, SRAM word width
- DEPTH, 2048, SRAM words
- ADDR_WIDTH, $clog2(DEPTH), SRAM address width
- LEN_WIDTH, ADDR_WIDTH+1, command length width (0..DEPTH words)

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid / cmd_ready  in / out  1  read-command handshake
- cmd_base  in  ADDR_WIDTH  first word address
- cmd_len  in  LEN_WIDTH  number of words to stream
- cmd_stride  in  ADDR_WIDTH  address increment (only with SRAM_RD_STRIDE_EN)
- busy  out  1  command in progress
- done  out  1  one-cycle pulse at command completion
- wr_valid  in  1  write request
- wr_ready  out  1  write accepted (constant 1 after reset)
- wr_addr / wr_data  in  ADDR_WIDTH / DATA_WIDTH  write address and data
- m_valid / m_ready  out / in  1  output stream handshake
- m_data  out  DATA_WIDTH  stream data
- m_last  out  1  final beat of command
- sram_en / sram_we  out  1  SRAM port enable / write enable
- sram_addr / sram_wdata  out  ADDR_WIDTH / DATA_WIDTH  SRAM address / write data
- sram_rdata  in  DATA_WIDTH  SRAM read data, valid the cycle after a read

## Operation
- FSM states: IDLE, RUN, DRAIN.
  - IDLE: cmd_ready=1. On handshake, latch base and remaining=len, then go to RUN. If len=0, go to IDLE with done pulsed next cycle.
  - RUN: issue reads. After the last read is issued, go to DRAIN.
  - DRAIN: wait until FIFO is empty and no read is in flight, then pulse done and go to IDLE.
- Port mux, per cycle:
  - wr_valid=1 → sram_en=1, sram_we=1, wr_addr/wr_data driven. No read is issued that cycle.
  - Otherwise a read is issued iff: state=RUN, remaining>0, and (fifo_cnt + inflight − pop) < 2, where pop = m_valid & m_ready.
  - Idle port: sram_en=0, sram_we=0.
- Read issue: sram_addr=cur_addr. Then cur_addr += 1 (mod DEPTH, natural wrap), remaining −= 1, and an inflight flag is set. The next cycle, sram_rdata is pushed to the FIFO. Beat tag last = (remaining was 1).
- Writes may starve reads; this is intended (the DMA is bounded).
- FIFO is 2 entries. m_valid = not empty; m_data/m_last come from the head entry.
- cmd_valid outside IDLE is ignored (cmd_ready=0).

## Timing
- Reset values: cmd_ready=1, wr_ready=1, and all other outputs 0. Outputs are cleared immediately on rst_n fall. FIFO, inflight flag and counters clear; an in-flight read is discarded.
- Command accepted at edge T: first sram_en read at cycle T+1, first m_valid at T+2.
- Sustained throughput is 1 beat/cycle with m_ready=1 and no writes.
- done is asserted in the cycle after the final beat's handshake. busy falls and cmd_ready rises in that same cycle.
- With len=0, done is asserted at T+1 and no SRAM access occurs.
- The buffer never holds more than 2 beats, counting in-flight reads.

## Configuration
- SRAM_RD_STRIDE_EN defined: cmd_stride port exists and is latched with the command. The address increment is the stride, mod DEPTH. A stride of 0 re-reads the base address.
- Undefined: no cmd_stride port; the increment is fixed at 1.

## Structure
- Package sram_stream_pkg: state enum (IDLE/RUN/DRAIN) and localparam RD_FIFO_DEPTH=2.
- Sub-module sram_rd_fifo2: 2-entry FIFO holding {last, data} with push/pop/count. The top level keeps the FSM, issue logic and port mux.

## Test plan
- base=10, len=4, m_ready=1, mem[i]=i: reads at 10,11,12,13 on consecutive cycles; m_data 10..13; m_last on beat 4; done one cycle later.
- Same command, m_ready low for 5 cycles after beat 1: at most 2 beats held, sram_en read stalls, all 4 beats delivered once in order.
- Write wr_addr=12, data=0xAA asserted the cycle a read of 12 would issue: write takes the port, the read slips one cycle, beat 3 = 0xAA.
- Wrap: base=DEPTH−2, len=4 → addresses 2046, 2047, 0, 1. With the macro: stride=3, base=0, len=3 → addresses 0, 3, 6.
- len=0: no sram_en, done at T+1, cmd_ready back to 1.
- rst_n pulsed low mid-stream: outputs clear the same cycle; after release, cmd_ready=1 and a new command streams correctly.
